serial_byte_deserializer: RTL

Upstream stage of the even/odd classifier. Collects a framed serial bit stream into DATA_W-bit words. Each completed word is presented as a one-cycle out_valid pulse with data_out, which map directly onto the classifier's in_valid/data_in. Supports an optional even-parity check bit and reports framing errors.

---
 rtl/serdes_pkg.sv | 15 +
 rtl/serial_byte_deserializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serdes_pkg.sv
// Shared constants for the serial front end and the even/odd classifier
// behind it: FSM state encoding and the default word width.
package serdes_pkg;

  // Default word width, also imported by the downstream classifier.
  localparam int DEFAULT_DATA_W = 8;

  // Deserializer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

endpackage

// File: rtl/serial_byte_deserializer.sv
// Collects a framed serial bit stream (sof-marked first bit, optional even
// parity bit) into DATA_W-bit words. Each finished word is presented as a
// one-cycle out_valid pulse. An sof arriving inside a frame aborts that
// frame with a frame_err pulse and starts a new frame on the same beat.
module serial_byte_deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_valid,
  input  logic              ser_bit,
  input  logic              ser_sof,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  // Writes bit b into word at serial position pos, honouring the bit order.
  function automatic logic [DATA_W-1:0] put_bit(input logic [DATA_W-1:0] word,
                                                input logic [CNT_W-1:0]  pos,
                                                input logic              b);
    logic [DATA_W-1:0] w;
    w = word;
    for (int i = 0; i < DATA_W; i++) begin
      if (LSB_FIRST ? (CNT_W'(i) == pos) : (CNT_W'(DATA_W - 1 - i) == pos)) begin
        w[i] = b;
      end
    end
    return w;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              out_valid_q, out_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  logic sof_beat;
  logic data_beat;
  logic restart;      // this beat is data bit 0 of a new frame
  logic store;        // this beat is a data bit of the current frame
  logic close;        // this beat completes the frame (last data or parity bit)
  logic frame_abort;  // a frame in progress is dropped by this sof

  assign sof_beat  = ser_valid & ser_sof;
  assign data_beat = ser_valid & ~ser_sof;

  // Next-state logic and per-beat control strobes; sof always takes priority.
  always_comb begin
    state_d     = state_q;
    restart     = 1'b0;
    store       = 1'b0;
    close       = 1'b0;
    frame_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sof_beat) begin
          restart = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sof_beat) begin
          restart     = 1'b1;
          frame_abort = 1'b1;
        end else if (data_beat) begin
          store = 1'b1;
          if (cnt_q == LAST_IDX) begin
            if (PARITY_EN) begin
              state_d = ST_PAR;
            end else begin
              close   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_PAR: begin
        if (sof_beat) begin
          restart     = 1'b1;
          frame_abort = 1'b1;
          state_d     = ST_SHIFT;
        end else if (data_beat) begin
          close   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit counter: 1 after the first data bit, cleared when a frame closes.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = CNT_W'(1);
    end else if (close) begin
      cnt_d = '0;
    end else if (store) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Shift register: a restart clears stale bits from an aborted frame.
  always_comb begin
    shreg_d = shreg_q;
    if (restart) begin
      shreg_d = put_bit('0, '0, ser_bit);
    end else if (store) begin
      shreg_d = put_bit(shreg_q, cnt_q, ser_bit);
    end
  end

  // Output pulses; in the parity state ser_bit is the received parity bit.
  always_comb begin
    data_d       = data_q;
    out_valid_d  = close;
    frame_err_d  = frame_abort;
    parity_err_d = 1'b0;
    if (close) begin
      data_d       = shreg_d;
      parity_err_d = PARITY_EN & ((^shreg_q) ^ ser_bit);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // Registered word and single-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
